// File: rtl/gecko_execute_muldiv_if.sv
// Command/result bundle between decode and the iterative RV32M multiply/divide unit.
// Decode side uses the master modport; the execute unit uses the slave modport.
interface gecko_execute_muldiv_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [DATA_WIDTH-1:0]     cmd_a;
  logic [DATA_WIDTH-1:0]     cmd_b;
  logic                      cmd_reuse_a;
  logic                      cmd_reuse_b;
  logic [REG_ADDR_WIDTH-1:0] cmd_reg_addr;
  logic                      cmd_speculative;
  logic                      flush;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_WIDTH-1:0]     res_value;
  logic [REG_ADDR_WIDTH-1:0] res_reg_addr;
  logic                      res_speculative;
  logic                      busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_reuse_a, cmd_reuse_b,
           cmd_reg_addr, cmd_speculative, flush, res_ready,
    input  cmd_ready, res_valid, res_value, res_reg_addr, res_speculative, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_reuse_a, cmd_reuse_b,
           cmd_reg_addr, cmd_speculative, flush, res_ready,
    output cmd_ready, res_valid, res_value, res_reg_addr, res_speculative, busy
  );
endinterface

// File: rtl/gecko_execute_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, RADIX_BITS per cycle.
// Optional GECKO_MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module gecko_execute_muldiv #(
  parameter int DATA_WIDTH     = 32,
  parameter int RADIX_BITS     = 1,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  gecko_execute_muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int R  = RADIX_BITS;
  localparam int N  = W / R;
  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] ITERATE = 3'd2;
  localparam logic [2:0] FINISH  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]                state_reg;
  logic [2:0]                op_reg;
  logic [W-1:0]              a_reg, b_reg;
  logic [REG_ADDR_WIDTH-1:0] addr_reg;
  logic                      spec_reg;
  logic                      neg_reg;
  logic [W-1:0]              opa_reg;          // multiplier, or dividend shifting into quotient
  logic [2*W-1:0]            opb_reg;          // multiplicand (shifted left), or divisor
  logic [2*W-1:0]            acc_reg;          // product, or partial remainder in the low word
  logic [CW-1:0]             cnt_reg;
  logic [W-1:0]              res_value_reg;
  logic [W-1:0]              last_result_reg;

  logic           is_div, a_neg, b_neg, div_zero, overflow, flush_hit, iter_last;
  logic [W-1:0]   a_mag, b_mag, special_value, div_raw, div_word, finish_value;
  logic [2*W-1:0] mul_acc_next, mul_full;

  assign is_div    = op_reg[2];
  assign a_neg     = a_reg[W-1] & ((op_reg == 3'd1) | (op_reg == 3'd2) | (is_div & ~op_reg[0]));
  assign b_neg     = b_reg[W-1] & ((op_reg == 3'd1) | (is_div & ~op_reg[0]));
  assign a_mag     = a_neg ? -a_reg : a_reg;
  assign b_mag     = b_neg ? -b_reg : b_reg;
  assign div_zero  = is_div && (b_reg == '0);
  assign overflow  = is_div && !op_reg[0] && (a_reg == {1'b1, {(W-1){1'b0}}}) && (b_reg == '1);
  assign special_value = div_zero ? (op_reg[1] ? a_reg : '1) : (op_reg[1] ? '0 : a_reg);
  assign flush_hit = bus.flush && spec_reg && (state_reg != IDLE);

  assign mul_acc_next = acc_reg + opb_reg * {{(2*W-R){1'b0}}, opa_reg[R-1:0]};

  // Restoring divide, one quotient bit per chained stage.
  genvar gi;
  for (gi = 0; gi < R; gi++) begin : g_div_step
    logic [W-1:0] rem_in, quo_in, rem_out, quo_out, diff;
    logic [W:0]   shifted;
    logic         fits;
    if (gi == 0) begin : g_first
      assign rem_in = acc_reg[W-1:0];
      assign quo_in = opa_reg;
    end else begin : g_chain
      assign rem_in = g_div_step[gi-1].rem_out;
      assign quo_in = g_div_step[gi-1].quo_out;
    end
    assign shifted = {rem_in, quo_in[W-1]};
    assign fits    = shifted >= {1'b0, opb_reg[W-1:0]};
    assign diff    = shifted[W-1:0] - opb_reg[W-1:0];
    assign rem_out = fits ? diff : shifted[W-1:0];
    assign quo_out = {quo_in[W-2:0], fits};
  end

`ifdef GECKO_MULDIV_EARLY_OUT_EN
  assign iter_last = (cnt_reg == '0) || (!is_div && ((opa_reg >> R) == '0));
`else
  assign iter_last = (cnt_reg == '0);
`endif

  assign mul_full     = neg_reg ? -acc_reg : acc_reg;
  assign div_raw      = op_reg[1] ? acc_reg[W-1:0] : opa_reg;
  assign div_word     = neg_reg ? -div_raw : div_raw;
  assign finish_value = is_div ? div_word :
                        ((op_reg[1:0] == 2'd0) ? mul_full[W-1:0] : mul_full[2*W-1:W]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      op_reg          <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      addr_reg        <= '0;
      spec_reg        <= 1'b0;
      neg_reg         <= 1'b0;
      opa_reg         <= '0;
      opb_reg         <= '0;
      acc_reg         <= '0;
      cnt_reg         <= '0;
      res_value_reg   <= '0;
      last_result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.cmd_valid) begin
          op_reg    <= bus.cmd_op;
          a_reg     <= bus.cmd_reuse_a ? last_result_reg : bus.cmd_a;
          b_reg     <= bus.cmd_reuse_b ? last_result_reg : bus.cmd_b;
          addr_reg  <= bus.cmd_reg_addr;
          spec_reg  <= bus.cmd_speculative;
          state_reg <= SETUP;
        end
        SETUP: begin
          neg_reg <= (is_div && op_reg[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero || overflow) begin
            res_value_reg <= special_value;
            state_reg     <= DONE;
          end else begin
            opa_reg   <= is_div ? a_mag : b_mag;
            opb_reg   <= {{W{1'b0}}, is_div ? b_mag : a_mag};
            acc_reg   <= '0;
            cnt_reg   <= CW'(N - 1);
            state_reg <= ITERATE;
          end
        end
        ITERATE: begin
          if (is_div) begin
            acc_reg <= {{W{1'b0}}, g_div_step[R-1].rem_out};
            opa_reg <= g_div_step[R-1].quo_out;
          end else begin
            acc_reg <= mul_acc_next;
            opb_reg <= opb_reg << R;
            opa_reg <= opa_reg >> R;
          end
          cnt_reg <= cnt_reg - CW'(1);
          if (iter_last) state_reg <= FINISH;
        end
        FINISH: begin
          res_value_reg <= finish_value;
          state_reg     <= DONE;
        end
        DONE: if (bus.res_ready && !flush_hit) begin
          last_result_reg <= res_value_reg;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
      // A flush of speculative work overrides whatever the state machine chose.
      if (flush_hit) state_reg <= IDLE;
    end
  end

  assign bus.cmd_ready       = (state_reg == IDLE) && rst;
  assign bus.res_valid       = (state_reg == DONE);
  assign bus.res_value       = res_value_reg;
  assign bus.res_reg_addr    = addr_reg;
  assign bus.res_speculative = spec_reg;
  assign bus.busy            = (state_reg != IDLE);
endmodule
